// File: rtl/rsa_modexp_stream.sv
// Streaming RSA modular exponentiation C = M^E mod N with a radix-2 bit-serial
// Montgomery multiplier (R = 2^WIDTH), valid/ready request and response handshakes.
module rsa_modexp_stream #(
    parameter int WIDTH  = 64,
    parameter int E_BITS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  M,
    input  logic [E_BITS-1:0] E,
    input  logic [WIDTH-1:0]  N,
    input  logic [WIDTH-1:0]  R2_MOD_N,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  C,
    output logic              err,
    output logic              busy
);

    localparam int MC_W = $clog2(WIDTH + 1);
    localparam int EC_W = $clog2(E_BITS + 1);
    localparam logic [MC_W-1:0]  MC_LAST = MC_W'(WIDTH);
    localparam logic [EC_W-1:0]  EC_FULL = EC_W'(E_BITS);
    localparam logic [EC_W-1:0]  EC_ONE  = EC_W'(1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] THREE   = WIDTH'(3);

    typedef enum logic [3:0] {
        IDLE, CHECK, TOMONT, INIT, SCAN, SQR, MUL, FROMMONT, DONE
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  m_reg;
    logic [WIDTH-1:0]  n_reg;
    logic [WIDTH-1:0]  r2_reg;
    logic [E_BITS-1:0] e_reg;
    logic [EC_W-1:0]   cnt;
    logic [MC_W-1:0]   mcnt;
    logic [WIDTH+1:0]  s_acc;
    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_op;
    logic [WIDTH-1:0]  x_reg;
    logic [WIDTH-1:0]  mbar_reg;
    logic [WIDTH-1:0]  mont_res;
    logic              mont_done;
    logic              mont_active;

    // One reduction step: add A[i]*B, make even with N, halve. Stays below 2N.
    function automatic logic [WIDTH+1:0] mont_step(input logic [WIDTH+1:0] s,
                                                   input logic             a_bit,
                                                   input logic [WIDTH-1:0] b,
                                                   input logic [WIDTH-1:0] n);
        logic [WIDTH+1:0] t;
        t = s + (a_bit ? {2'b00, b} : '0);
        if (t[0])
            t = t + {2'b00, n};
        return t >> 1;
    endfunction

    function automatic logic [WIDTH-1:0] mont_final(input logic [WIDTH+1:0] s,
                                                    input logic [WIDTH-1:0] n);
        logic [WIDTH+1:0] r;
        r = (s >= {2'b00, n}) ? s - {2'b00, n} : s;
        return r[WIDTH-1:0];
    endfunction

    assign mont_res    = mont_final(s_acc, n_reg);
    assign mont_done   = (mcnt == MC_LAST);
    assign mont_active = state inside {TOMONT, INIT, SQR, MUL, FROMMONT};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            C         <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // Shared multiplier sequencing; operand loads happen on state exits below.
            if (mont_active) begin
                if (!mont_done) begin
                    s_acc <= mont_step(s_acc, a_sh[0], b_op, n_reg);
                    a_sh  <= a_sh >> 1;
                    mcnt  <= mcnt + MC_W'(1);
                end else begin
                    s_acc <= '0;
                    mcnt  <= '0;
                end
            end

            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        m_reg    <= M;
                        e_reg    <= E;
                        n_reg    <= N;
                        r2_reg   <= R2_MOD_N;
                        err      <= 1'b0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= CHECK;
                    end
                end

                CHECK: begin
                    s_acc <= '0;
                    mcnt  <= '0;
                    cnt   <= EC_FULL;
                    if (!n_reg[0] || (n_reg < THREE) || (m_reg >= n_reg)) begin
                        err   <= 1'b1;
                        C     <= '0;
                        state <= DONE;
                    end else begin
                        a_sh  <= m_reg;
                        b_op  <= r2_reg;
                        state <= TOMONT;
                    end
                end

                TOMONT: begin
                    if (mont_done) begin
                        mbar_reg <= mont_res;
                        a_sh     <= ONE;
                        b_op     <= r2_reg;
                        state    <= INIT;
                    end
                end

                INIT: begin
                    if (mont_done) begin
                        x_reg <= mont_res;
                        if (e_reg[E_BITS-1]) begin
                            a_sh  <= mont_res;
                            b_op  <= mont_res;
                            state <= SQR;
                        end else begin
                            state <= SCAN;
                        end
                    end
                end

                // Leading-zero skip: one cycle per zero, exits on the first set bit.
                SCAN: begin
                    e_reg <= e_reg << 1;
                    cnt   <= cnt - EC_ONE;
                    if (cnt == EC_ONE) begin
                        a_sh  <= x_reg;
                        b_op  <= ONE;
                        state <= FROMMONT;
                    end else if (e_reg[E_BITS-2]) begin
                        a_sh  <= x_reg;
                        b_op  <= x_reg;
                        state <= SQR;
                    end
                end

                SQR, MUL: begin
                    if (mont_done) begin
                        x_reg <= mont_res;
                        a_sh  <= mont_res;
                        if (state == SQR && e_reg[E_BITS-1]) begin
                            b_op  <= mbar_reg;
                            state <= MUL;
                        end else begin
                            e_reg <= e_reg << 1;
                            cnt   <= cnt - EC_ONE;
                            if (cnt == EC_ONE) begin
                                b_op  <= ONE;
                                state <= FROMMONT;
                            end else begin
                                b_op  <= mont_res;
                                state <= SQR;
                            end
                        end
                    end
                end

                FROMMONT: begin
                    if (mont_done) begin
                        C         <= mont_res;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end

                // Error path arrives with out_valid low and raises it here.
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_modexp_stream.sv
// Directed bench for rsa_modexp_stream: a 64-bit instance for function, latency,
// errors, backpressure and reset abort, plus an 8-bit instance for the small build.
module tb_rsa_modexp_stream;

    logic        clk;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, err_o, busy_o;
    logic [63:0] m_i, e_i, n_i, r2_i, c_o;

    logic        in_valid_8, in_ready_8, out_valid_8, out_ready_8, err_8, busy_8;
    logic [7:0]  m_8, e_8, n_8, r2_8, c_8;

    int vectors     = 0;
    int miscompares = 0;

    rsa_modexp_stream #(.WIDTH(64), .E_BITS(64)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .M(m_i), .E(e_i), .N(n_i), .R2_MOD_N(r2_i),
        .out_valid(out_valid), .out_ready(out_ready), .C(c_o), .err(err_o), .busy(busy_o)
    );

    rsa_modexp_stream #(.WIDTH(8), .E_BITS(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid_8), .in_ready(in_ready_8),
        .M(m_8), .E(e_8), .N(n_8), .R2_MOD_N(r2_8),
        .out_valid(out_valid_8), .out_ready(out_ready_8), .C(c_8), .err(err_8), .busy(busy_8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Plain square-and-multiply reference, LSB first.
    function automatic longint unsigned modexp(input longint unsigned b,
                                               input longint unsigned e,
                                               input longint unsigned n);
        longint unsigned r, x;
        r = 1;
        x = b % n;
        for (int i = 0; i < 64; i++) begin
            if (e[i]) r = (r * x) % n;
            x = (x * x) % n;
        end
        return r;
    endfunction

    task automatic run64(input string tag, input logic [63:0] m, input logic [63:0] e,
                         input logic [63:0] n, input logic [63:0] r2, input int exp_lat,
                         input logic [63:0] exp_c, input logic exp_err, input int hold);
        int lat;
        @(negedge clk);
        check_val($sformatf("%s_in_ready_idle", tag), in_ready, 1);
        m_i = m; e_i = e; n_i = n; r2_i = r2;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(negedge clk);
        in_valid = 1'b0;
        check_val($sformatf("%s_busy", tag), busy_o, 1);
        check_val($sformatf("%s_in_ready_busy", tag), in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 20000) begin
            @(negedge clk);
            lat++;
        end
        check_val($sformatf("%s_latency", tag), 64'(lat), 64'(exp_lat));
        check_val($sformatf("%s_c", tag), c_o, exp_c);
        check_val($sformatf("%s_err", tag), err_o, exp_err);
        for (int i = 0; i < hold; i++) begin
            check_val($sformatf("%s_hold_valid", tag), out_valid, 1);
            check_val($sformatf("%s_hold_c", tag), c_o, exp_c);
            check_val($sformatf("%s_hold_in_ready", tag), in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_val($sformatf("%s_out_valid_drop", tag), out_valid, 0);
        check_val($sformatf("%s_in_ready_back", tag), in_ready, 1);
        check_val($sformatf("%s_busy_drop", tag), busy_o, 0);
    endtask

    task automatic run8(input string tag, input logic [7:0] m, input logic [7:0] e,
                        input logic [7:0] n, input logic [7:0] r2, input logic [7:0] exp_c);
        int lat;
        @(negedge clk);
        check_val($sformatf("%s_in_ready_idle", tag), in_ready_8, 1);
        m_8 = m; e_8 = e; n_8 = n; r2_8 = r2;
        in_valid_8 = 1'b1;
        @(negedge clk);
        in_valid_8 = 1'b0;
        lat = 0;
        while (!out_valid_8 && lat < 5000) begin
            @(negedge clk);
            lat++;
        end
        check_val($sformatf("%s_done", tag), out_valid_8, 1);
        check_val($sformatf("%s_c", tag), c_8, exp_c);
        check_val($sformatf("%s_err", tag), err_8, 0);
        @(negedge clk);
        check_val($sformatf("%s_in_ready_back", tag), in_ready_8, 1);
    endtask

    initial begin
        bit saw_valid;
        logic [7:0] ref200;
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1;
        m_i = '0; e_i = '0; n_i = '0; r2_i = '0;
        in_valid_8 = 1'b0; out_ready_8 = 1'b1;
        m_8 = '0; e_8 = '0; n_8 = '0; r2_8 = '0;
        repeat (3) @(negedge clk);
        check_val("reset_in_ready", in_ready, 1);
        check_val("reset_out_valid", out_valid, 0);
        check_val("reset_c", c_o, 0);
        check_val("reset_err", err_o, 0);
        check_val("reset_busy", busy_o, 0);
        check_val("reset8_in_ready", in_ready_8, 1);
        check_val("reset8_out_valid", out_valid_8, 0);
        rst = 1'b0;

        // 5^3 mod 11 = 4; 2^10 mod 11 = 1; 7^0 = 1
        run64("pow_5_3", 64'd5, 64'd3, 64'd11, 64'd3, 518, 64'd4, 1'b0, 0);
        run64("pow_2_10", 64'd2, 64'd10, 64'd11, 64'd3, 646, 64'd1, 1'b0, 0);
        run64("pow_e0", 64'd7, 64'd0, 64'd11, 64'd3, 260, 64'd1, 1'b0, 0);

        run64("err_even_n", 64'd3, 64'd3, 64'd10, 64'd3, 2, 64'd0, 1'b1, 0);
        run64("err_m_ge_n", 64'd12, 64'd3, 64'd11, 64'd3, 2, 64'd0, 1'b1, 0);
        run64("err_n_one", 64'd0, 64'd3, 64'd1, 64'd0, 2, 64'd0, 1'b1, 0);

        run64("backpressure", 64'd5, 64'd3, 64'd11, 64'd3, 518, 64'd4, 1'b0, 50);

        // Abort an operation partway through
        @(negedge clk);
        m_i = 64'd5; e_i = 64'd3; n_i = 64'd11; r2_i = 64'd3;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (199) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("abort_out_valid", out_valid, 0);
        check_val("abort_c", c_o, 0);
        check_val("abort_err", err_o, 0);
        check_val("abort_busy", busy_o, 0);
        check_val("abort_in_ready", in_ready, 1);
        saw_valid = 1'b0;
        repeat (600) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        check_val("abort_no_pulse", saw_valid, 0);
        run64("after_abort", 64'd3, 64'd5, 64'd11, 64'd3, 582, 64'd1, 1'b0, 0);

        // 8-bit build
        run8("w8_5_3", 8'd5, 8'd3, 8'd11, 8'd9, 8'd4);
        ref200 = 8'(modexp(64'd200, 64'd255, 64'd251));
        run8("w8_200_255", 8'd200, 8'd255, 8'd251, 8'd25, ref200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
